// File: rtl/gate_bist.sv
// Built-in self-test engine: sweeps every input pattern into an N-input gate and checks its output.
// Optional build macro GATE_BIST_STOP_ON_FAIL_EN ends a run at the first mismatch.
module gate_bist #(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          gate_sel,
    output logic [N_INPUTS-1:0] pat_out,
    input  logic                dut_y,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          err_count,
    output logic [N_INPUTS-1:0] fail_pattern
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    sel_q;
    logic [SW-1:0] settle_cnt;
    logic          mismatch;
    logic          last_pat;
    logic          stop_now;

    function automatic logic expected_y(input logic [2:0] sel, input logic [N_INPUTS-1:0] p);
        case (sel)
            3'd0:    expected_y = &p;
            3'd1:    expected_y = |p;
            3'd2:    expected_y = ~&p;
            3'd3:    expected_y = ~|p;
            3'd4:    expected_y = ^p;
            3'd5:    expected_y = ~^p;
            default: expected_y = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        sat_inc = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign mismatch = (dut_y != expected_y(sel_q, pat_out));
    assign last_pat = &pat_out;
`ifdef GATE_BIST_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (gate_sel <= 3'd5) ? APPLY : DONE;
            end
            APPLY: begin
                if (settle_cnt == '0) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                state_nxt = (last_pat || stop_now) ? DONE : APPLY;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q        <= '0;
            settle_cnt   <= '0;
            pat_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_pattern <= '0;
        end else begin
            // busy/done lag the state by one edge so busy drops exactly as done rises
            busy <= (state == APPLY) || (state == SAMPLE);
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        pass         <= 1'b0;
                        fail_pattern <= '0;
                        if (gate_sel <= 3'd5) begin
                            sel_q      <= gate_sel;
                            err_count  <= '0;
                            pat_out    <= '0;
                            settle_cnt <= SETTLE_LOAD;
                        end else begin
                            err_count <= 8'hFF;
                        end
                    end
                end
                APPLY: begin
                    if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
                end
                SAMPLE: begin
                    if (mismatch) begin
`ifdef GATE_BIST_STOP_ON_FAIL_EN
                        err_count <= 8'd1;
`else
                        err_count <= sat_inc(err_count);
`endif
                        if (err_count == '0) fail_pattern <= pat_out;
                    end
                    if (!last_pat && !stop_now) begin
                        pat_out    <= pat_out + 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                DONE: begin
                    pass <= (err_count == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// Directed testbench for gate_bist (N_INPUTS=2, SETTLE_CYCLES=1) with a behavioural gate model.
module tb_gate_bist;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic [1:0] pat_out;
    logic       dut_y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [1:0] fail_pattern;

    int checks = 0;
    int errors = 0;

    logic [2:0] model_sel = 3'd0;
    int         model_mode = 0;

    gate_bist #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel),
        .pat_out(pat_out), .dut_y(dut_y), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .fail_pattern(fail_pattern)
    );

    always #5 clk = ~clk;

    // mode 0: healthy gate, 1: output stuck at 0, 2: output stuck at 1
    always_comb begin
        dut_y = 1'b0;
        case (model_mode)
            1: dut_y = 1'b0;
            2: dut_y = 1'b1;
            default: begin
                case (model_sel)
                    3'd0: dut_y = pat_out[0] & pat_out[1];
                    3'd1: dut_y = pat_out[0] | pat_out[1];
                    3'd2: dut_y = !(pat_out[0] & pat_out[1]);
                    3'd3: dut_y = !(pat_out[0] | pat_out[1]);
                    3'd4: dut_y = pat_out[0] != pat_out[1];
                    3'd5: dut_y = pat_out[0] == pat_out[1];
                    default: dut_y = 1'b0;
                endcase
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, wait (bounded) for done and check the run results.
    task automatic run(input string tag, input logic [2:0] sel, input int mode,
                       input int exp_edge, input logic [7:0] exp_err,
                       input logic [1:0] exp_fail, input logic exp_pass,
                       input bit chk_seq, input int glitch_edge);
        int e;
        bit seen_busy;
        model_sel  = sel;
        model_mode = mode;
        gate_sel   = sel;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_pass_clr"}, 32'(pass), 32'd0);
        chk({tag, "_busy_e0"}, 32'(busy), 32'd0);
        e = 0;
        seen_busy = 1'b0;
        while (!done && e < 40) begin
            if (e == glitch_edge) begin
                start    = 1'b1;
                gate_sel = 3'd7;
            end
            tick();
            start = 1'b0;
            e++;
            if (busy) seen_busy = 1'b1;
            if (chk_seq && e <= 8)
                chk({tag, "_pat"}, 32'(pat_out), (e < 8) ? 32'(e / 2) : 32'd3);
        end
        chk({tag, "_done_edge"}, 32'(e), 32'(exp_edge));
        chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_fail_pat"}, 32'(fail_pattern), 32'(exp_fail));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_busy_seen"}, 32'(seen_busy), (exp_edge > 1) ? 32'd1 : 32'd0);
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_pass_held"}, 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_pat", 32'(pat_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_fail", 32'(fail_pattern), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        run("and_ok", 3'd0, 0, 9, 8'd0, 2'b00, 1'b1, 1'b1, -1);
        run("and_sa0", 3'd0, 1, 9, 8'd1, 2'b11, 1'b0, 1'b0, -1);
`ifdef GATE_BIST_STOP_ON_FAIL_EN
        run("nor_sa1", 3'd3, 2, 5, 8'd1, 2'b01, 1'b0, 1'b0, -1);
`else
        run("nor_sa1", 3'd3, 2, 9, 8'd3, 2'b01, 1'b0, 1'b0, -1);
`endif
        run("xnor_ok", 3'd5, 0, 9, 8'd0, 2'b00, 1'b1, 1'b0, -1);
        run("rsvd7", 3'd7, 0, 1, 8'hFF, 2'b00, 1'b0, 1'b0, -1);

        // asynchronous reset in the middle of a failing XOR run
        model_sel  = 3'd4;
        model_mode = 2;
        gate_sel   = 3'd4;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pat", 32'(pat_out), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err_count), 32'd0);
        chk("midrst_fail", 32'(fail_pattern), 32'd0);
        chk("midrst_pass", 32'(pass), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle_busy", 32'(busy), 32'd0);
        tick();
        chk("post_rst_idle_done", 32'(done), 32'd0);
        run("xor_ok_glitch", 3'd4, 0, 9, 8'd0, 2'b00, 1'b1, 1'b0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
# gate_bist

Synthesizable built-in self-test engine for the logic-gate library. It drives every input combination into an N-input gate under test and samples the gate's output. It compares each sample against the expected truth table for the selected gate type and reports pass/fail, an error count and the first failing pattern. It sits beside a gate instance as its on-chip stimulus and checking counterpart.

## Interface
- `N_INPUTS`, default 2: width of the gate input vector (1..8); patterns run 0 .. 2^N_INPUTS-1.
- `SETTLE_CYCLES`, default 1: cycles each pattern is held before sampling (>=1).
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  single-cycle request to begin a run; accepted only in IDLE.
- `gate_sel`  input  3  gate type: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6/7 reserved. Latched when `start` is accepted.
- `pat_out`  output  N_INPUTS  pattern driven to the gate inputs (bit 0 = input `a`).
- `dut_y`  input  1  gate output being checked.
- `busy`  output  1  high from the cycle after `start` is accepted until `done`.
- `done`  output  1  one-cycle pulse at the end of a run.
- `pass`  output  1  1 if the last run had zero mismatches; held until the next accepted `start`.
- `err_count`  output  8  mismatch count for the last run; saturates at 255.
- `fail_pattern`  output  N_INPUTS  first pattern that mismatched; 0 if none.

## Operation
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- **IDLE**
  - `start`=1 with a legal `gate_sel`: latch `gate_sel`, clear `err_count`, `fail_pattern` and `pass`, set `pat_out`=0, go to APPLY.
  - `start`=1 with a reserved `gate_sel`: go to DONE with `pass`=0, `err_count`=8'hFF, `fail_pattern`=0.
- **APPLY**
  - Hold `pat_out` for SETTLE_CYCLES cycles using the settle counter, then go to SAMPLE.
- **SAMPLE**
  - Compare `dut_y` with expected(`pat_out`). Expected is the reduction over all N_INPUTS bits: &, |, ~&, ~|, ^, ~^.
  - On a mismatch, increment `err_count` (saturating at 255). If this is the first mismatch of the run, capture `pat_out` into `fail_pattern`.
  - If `pat_out` = all-ones, go to DONE. Otherwise increment `pat_out`, reload the settle counter and go to APPLY.
- **DONE**
  - Assert `done` for one cycle.
  - `pass` = (`err_count`==0), registered in the same cycle `done` is high.
  - Go to IDLE. `pat_out` keeps its last value until the next run.
- `start` is ignored while `busy`=1 or in DONE.
- `dut_y` is sampled only in SAMPLE; its value in any other state has no effect.

## Timing
- Reset values: `pat_out`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_pattern`=0, FSM in IDLE, settle counter=0.
- Each pattern takes SETTLE_CYCLES+1 cycles.
- `start` is sampled at edge 0. `done` is high in the cycle after edge 2^N_INPUTS×(SETTLE_CYCLES+1)+1. For N=2 and SETTLE=1, `done` is high for the cycle following edge 9.
- `busy` rises at edge 1 and falls in the same edge that raises `done`.
- Reserved `gate_sel`: `done` is high after edge 1 and `busy` never rises.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronous). After release the block idles and needs a new `start`.
- A mismatch on the last pattern is still counted and visible when `done` is high.

## Configuration
- `GATE_BIST_STOP_ON_FAIL_EN`
  - Defined: the first mismatch in SAMPLE goes directly to DONE with `err_count`=1 and `fail_pattern` = the failing pattern. The remaining patterns are not applied.
  - Undefined: all 2^N_INPUTS patterns always run and every mismatch is counted.

## Test plan
All scenarios use N_INPUTS=2, SETTLE_CYCLES=1, with a pulse on `start` at edge 0.
- Correct AND gate, `gate_sel`=0 → `done` after edge 9, `pass`=1, `err_count`=0, `fail_pattern`=0. `pat_out` sequence is 00,00,01,01,10,10,11,11.
- `dut_y` stuck at 0, `gate_sel`=0 → `pass`=0, `err_count`=1, `fail_pattern`=2'b11.
- `dut_y` stuck at 1, `gate_sel`=3 (NOR) → `err_count`=3, `fail_pattern`=2'b01.
  - With `GATE_BIST_STOP_ON_FAIL_EN` defined, the same stimulus gives `done` after edge 5 and `err_count`=1.
- `gate_sel`=7 → `done` after edge 1, `busy` stays 0, `pass`=0, `err_count`=8'hFF.
- Assert `rst_n`=0 at edge 4, release at edge 6, pulse `start` at edge 8 with a correct XOR gate (`gate_sel`=4) → outputs are at reset values during reset. The second run completes with `pass`=1 and a second `start` pulsed mid-run is ignored.
